adc_acq_sequencer: RTL and testbench

- Frame-acquisition controller for the serial ADC (ADS7883-style, WIDTH-bit samples, leading zero bit).
- Paces conversions at a fixed sample period and drives the ADC chip-select framing.
- Deserialises the ADC data line and writes each sample into the FFT input sample RAM.
- Signals frame completion to the FFT control; sits between the ADC pins and the FFT input buffer.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_shift_rx.sv | 43 ++++
 rtl/adc_acq_sequencer.sv | 153 +++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state type and timing constants for the ADC acquisition sequencer
package adc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CS    = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } adc_state_t;

    // The ADC emits one leading zero before the MSB of every conversion
    localparam int ADC_LEAD_BITS = 1;

    // Shortest legal conversion period: CS cycle + leading bit + data bits + write cycle
    function automatic int adc_min_period(input int width);
        return width + ADC_LEAD_BITS + 2;
    endfunction

endpackage

// File: rtl/adc_shift_rx.sv
// rtl/adc_shift_rx.sv - ADC serial deserialiser with leading-bit discard
module adc_shift_rx
    import adc_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic             i_sd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sample_valid
);

    localparam int TOTAL_BITS = ADC_LEAD_BITS + WIDTH;
    localparam int CW         = $clog2(TOTAL_BITS + 1);

    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             w_lead_bit;

    assign w_lead_bit     = (r_bit_cnt < CW'(ADC_LEAD_BITS));
    // High on the edge that captures the LSB, so the word is complete on the next cycle
    assign o_sample_valid = i_shift_en && (r_bit_cnt == CW'(TOTAL_BITS - 1));
    assign o_data         = r_shift;

    // Count captured edges; drop the leading bit(s), shift data bits in MSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= '0;
        end else if (i_shift_en && (r_bit_cnt != CW'(TOTAL_BITS))) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (!w_lead_bit) begin
                r_shift <= {r_shift[WIDTH-2:0], i_sd};
            end
        end
    end

endmodule

// File: rtl/adc_acq_sequencer.sv
// rtl/adc_acq_sequencer.sv - ADC frame acquisition controller feeding the FFT sample RAM
module adc_acq_sequencer
    import adc_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int N_SAMPLES = 128,
    parameter int PERIOD    = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         adc_cs,
    input  logic                         adc_sd,
    output logic                         wr_en,
    output logic [$clog2(N_SAMPLES)-1:0] wr_addr,
    output logic [WIDTH-1:0]             wr_data
);

    localparam int AW = $clog2(N_SAMPLES);
    localparam int PW = $clog2(PERIOD + 1);

    generate
        if (PERIOD < adc_min_period(WIDTH)) begin : g_period_check
            $fatal(1, "adc_acq_sequencer: PERIOD must be at least WIDTH+3");
        end
        if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_samples_check
            $fatal(1, "adc_acq_sequencer: N_SAMPLES must be a power of two >= 2");
        end
    endgenerate

    adc_state_t       r_state;
    adc_state_t       w_next_state;
    logic [AW-1:0]    r_sample_cnt;
    logic [PW-1:0]    r_period_cnt;
    logic             r_busy;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_wr_hold;

    logic             w_rx_clear;
    logic             w_shift_en;
    logic             w_sample_valid;
    logic [WIDTH-1:0] w_rx_data;
    logic             w_last_sample;
    logic             w_period_end;

    assign w_last_sample = (r_sample_cnt == AW'(N_SAMPLES - 1));
    assign w_period_end  = (r_period_cnt == PW'(PERIOD - 1));
    assign w_shift_en    = (r_state == S_SHIFT);
    assign w_rx_clear    = (r_state != S_SHIFT) || abort;

    adc_shift_rx #(
        .WIDTH (WIDTH)
    ) u_shift_rx (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_clear        (w_rx_clear),
        .i_shift_en     (w_shift_en),
        .i_sd           (adc_sd),
        .o_data         (w_rx_data),
        .o_sample_valid (w_sample_valid)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CS;
            S_CS:    w_next_state = S_SHIFT;
            S_SHIFT: if (w_sample_valid) w_next_state = S_WRITE;
            S_WRITE: begin
                // At the minimum period the write lands on the last period cycle, so skip WAIT
                if (w_last_sample)     w_next_state = S_DONE;
                else if (w_period_end) w_next_state = S_CS;
                else                   w_next_state = S_WAIT;
            end
            S_WAIT:  if (w_period_end) w_next_state = S_CS;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Period counter: zero in every CS cycle, free-running until the next CS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= '0;
        end else if ((w_next_state == S_CS) || (w_next_state == S_IDLE)) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // Sample counter: advances after each write, cleared whenever the frame ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_cnt <= '0;
        end else if (w_next_state == S_IDLE) begin
            r_sample_cnt <= '0;
        end else if ((r_state == S_WRITE) && !w_last_sample) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
        end
    end

    // Busy drops on the edge that enters DONE so it falls as done rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
        end
    end

    // Write address captured on entry to WRITE and held until the next write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr <= '0;
        end else if (w_next_state == S_WRITE) begin
            r_wr_addr <= r_sample_cnt;
        end
    end

    // Keep the last written sample so wr_data holds while the next one shifts in
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_hold <= '0;
        end else if (r_state == S_WRITE) begin
            r_wr_hold <= w_rx_data;
        end
    end

    assign busy    = r_busy;
    assign done    = (r_state == S_DONE);
    assign adc_cs  = (r_state == S_CS);
    assign wr_en   = (r_state == S_WRITE);
    assign wr_addr = r_wr_addr;
    assign wr_data = (r_state == S_WRITE) ? w_rx_data : r_wr_hold;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb/tb_adc_acq_sequencer.sv - directed self-checking bench for adc_acq_sequencer
module tb_adc_acq_sequencer;

    localparam int WIDTH   = 12;
    localparam int NS_A    = 8;
    localparam int PER_A   = 16;
    localparam int NS_B    = 128;
    localparam int PER_B   = 32;
    localparam int FRAME_A = 1 + NS_A * PER_A - PER_A + (WIDTH + 3) + 1;
    localparam int FRAME_B = 1 + NS_B * PER_B - PER_B + (WIDTH + 3) + 1;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             start   = 1'b0;
    logic             start_b = 1'b0;
    logic             abort   = 1'b0;
    logic             adc_sd  = 1'b0;
    logic             sd_b    = 1'b0;
    logic             busy, done, adc_cs, wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy_b, done_b, cs_b, wr_en_b;
    logic [6:0]       wr_addr_b;
    logic [WIDTH-1:0] wr_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_data [0:7];

    adc_acq_sequencer #(.WIDTH(WIDTH), .N_SAMPLES(NS_A), .PERIOD(PER_A)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .adc_cs(adc_cs), .adc_sd(adc_sd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    adc_acq_sequencer #(.WIDTH(WIDTH), .N_SAMPLES(NS_B), .PERIOD(PER_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
        .busy(busy_b), .done(done_b), .adc_cs(cs_b), .adc_sd(sd_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    always #5 clk = ~clk;

    // ADC model: leading zero on the first falling edge after CS, then MSB..LSB
    int               m_idx  = 0;
    int               m_bit  = 99;
    logic [WIDTH-1:0] m_word = '0;
    always @(negedge clk) begin
        if (!busy) begin
            m_idx  = 0;
            m_bit  = 99;
            adc_sd = 1'b0;
        end else if (adc_cs) begin
            m_word = model_data[m_idx[2:0]];
            m_idx  = m_idx + 1;
            m_bit  = 0;
            adc_sd = 1'b0;
        end else begin
            if (m_bit < 99) m_bit = m_bit + 1;
            if (m_bit >= 2 && m_bit <= WIDTH + 1) adc_sd = m_word[WIDTH + 1 - m_bit];
            else adc_sd = 1'b0;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (adc_cs !== 1'b0)   begin n_fail++; $display("FAIL reset_cs: got %b want 0", adc_cs); end
        n_checks++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (wr_addr !== 3'd0)  begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        n_checks++; if (wr_data !== 12'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_checks++; if (busy_b !== 1'b0)   begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int   n_wr = 0;
        int   n_done = 0;
        int   done_cyc = -1;
        int   first_wr = -1;
        logic busy_prev;
        @(negedge clk);
        start = 1'b1;
        busy_prev = busy;
        for (int cyc = 1; cyc <= FRAME_A + 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                n_checks++; if (adc_cs !== 1'b1) begin n_fail++; $display("FAIL frame_first_cs: got %b want 1", adc_cs); end
                n_checks++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL frame_busy_set: got %b want 1", busy); end
            end
            if (wr_en) begin
                if (first_wr < 0) first_wr = cyc;
                n_checks++; if (wr_addr !== 3'(n_wr)) begin n_fail++; $display("FAIL frame_addr%0d: got %0d want %0d", n_wr, wr_addr, n_wr); end
                n_checks++; if (n_wr > 7 || wr_data !== model_data[n_wr[2:0]]) begin n_fail++; $display("FAIL frame_data%0d: got %h want %h", n_wr, wr_data, model_data[n_wr[2:0]]); end
                n_wr++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL frame_busy_at_done: got %b want 0", busy); end
                n_checks++; if (busy_prev !== 1'b1) begin n_fail++; $display("FAIL frame_busy_before_done: got %b want 1", busy_prev); end
            end
            busy_prev = busy;
        end
        n_checks++; if (first_wr != WIDTH + 3) begin n_fail++; $display("FAIL frame_first_write_cycle: got %0d want %0d", first_wr, WIDTH + 3); end
        n_checks++; if (n_wr != NS_A)          begin n_fail++; $display("FAIL frame_write_count: got %0d want %0d", n_wr, NS_A); end
        n_checks++; if (n_done != 1)           begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", n_done); end
        n_checks++; if (done_cyc != FRAME_A - 1) begin n_fail++; $display("FAIL frame_length: got %0d want %0d", done_cyc, FRAME_A - 1); end
        n_checks++; if (wr_addr !== 3'd7)      begin n_fail++; $display("FAIL frame_addr_hold: got %0d want 7", wr_addr); end
        n_checks++; if (wr_data !== 12'h7FF)   begin n_fail++; $display("FAIL frame_data_hold: got %h want 7ff", wr_data); end
    endtask

    task automatic test_start_held();
        int n_wr = 0;
        int n_cs = 0;
        int n_done = 0;
        int done_cyc = -1;
        int got = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= FRAME_A + 10; cyc++) begin
            @(negedge clk);
            if (adc_cs) n_cs++;
            if (wr_en) begin
                n_checks++; if (wr_addr !== 3'(n_wr)) begin n_fail++; $display("FAIL held_addr%0d: got %0d want %0d", n_wr, wr_addr, n_wr); end
                n_wr++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                start = 1'b0;
            end
        end
        n_checks++; if (n_cs != NS_A)            begin n_fail++; $display("FAIL held_cs_count: got %0d want %0d", n_cs, NS_A); end
        n_checks++; if (n_done != 1)             begin n_fail++; $display("FAIL held_done_count: got %0d want 1", n_done); end
        n_checks++; if (done_cyc != FRAME_A - 1) begin n_fail++; $display("FAIL held_frame_length: got %0d want %0d", done_cyc, FRAME_A - 1); end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && got == 0; cyc++) begin
            @(negedge clk);
            if (wr_en) begin
                got = 1;
                n_checks++; if (wr_addr !== 3'd0) begin n_fail++; $display("FAIL restart_addr: got %0d want 0", wr_addr); end
            end
        end
        n_checks++; if (got != 1) begin n_fail++; $display("FAIL restart_timeout: got %0d writes want 1", got); end
        got = 0;
        for (int cyc = 0; cyc < FRAME_A + 10 && got == 0; cyc++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        n_checks++; if (got != 1) begin n_fail++; $display("FAIL restart_done_timeout: got %0d want 1", got); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int n_wr = 0;
        int n_done = 0;
        int n_cs_after = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_en) n_wr++;
            if (done) n_done++;
            if (cyc > 86 && (adc_cs || busy)) n_cs_after++;
            if (cyc == 85) abort = 1'b1;
            if (cyc == 86) begin
                n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
                n_checks++; if (adc_cs !== 1'b0) begin n_fail++; $display("FAIL abort_cs: got %b want 0", adc_cs); end
                abort = 1'b0;
            end
        end
        n_checks++; if (n_wr != 5)       begin n_fail++; $display("FAIL abort_write_count: got %0d want 5", n_wr); end
        n_checks++; if (n_done != 0)     begin n_fail++; $display("FAIL abort_done_count: got %0d want 0", n_done); end
        n_checks++; if (n_cs_after != 0) begin n_fail++; $display("FAIL abort_activity_after: got %0d want 0", n_cs_after); end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL idle_abort_busy: got %b want 0", busy); end
        n_checks++; if (adc_cs !== 1'b0) begin n_fail++; $display("FAIL idle_abort_cs: got %b want 0", adc_cs); end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL idle_abort_no_queue: got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (47) @(negedge clk);
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
        n_checks++; if (wr_addr !== 3'd2)   begin n_fail++; $display("FAIL pre_reset_addr: got %0d want 2", wr_addr); end
        n_checks++; if (wr_data !== 12'hFFF) begin n_fail++; $display("FAIL pre_reset_data: got %h want fff", wr_data); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        n_checks++; if (wr_addr !== 3'd0)   begin n_fail++; $display("FAIL async_reset_addr: got %0d want 0", wr_addr); end
        n_checks++; if (wr_data !== 12'h0)  begin n_fail++; $display("FAIL async_reset_data: got %h want 0", wr_data); end
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cs_pacing();
        int   n_cs = 0;
        int   n_wr = 0;
        int   last_rise = -1;
        int   done_cyc = -1;
        logic cs_prev = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        for (int cyc = 1; cyc <= FRAME_B + 40; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (cs_b) begin
                n_checks++; if (cs_prev !== 1'b0) begin n_fail++; $display("FAIL cs_width at cycle %0d: got 2+ want 1", cyc); end
                if (last_rise >= 0) begin
                    n_checks++; if (cyc - last_rise != PER_B) begin n_fail++; $display("FAIL cs_gap at cycle %0d: got %0d want %0d", cyc, cyc - last_rise, PER_B); end
                end else begin
                    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL cs_first: got %0d want 1", cyc); end
                end
                last_rise = cyc;
                n_cs++;
            end
            if (wr_en_b) n_wr++;
            if (done_b) begin
                done_cyc = cyc;
                n_checks++; if (wr_addr_b !== 7'd127) begin n_fail++; $display("FAIL pacing_last_addr: got %0d want 127", wr_addr_b); end
                n_checks++; if (wr_data_b !== 12'h0)  begin n_fail++; $display("FAIL pacing_last_data: got %h want 0", wr_data_b); end
            end
            cs_prev = cs_b;
        end
        n_checks++; if (n_cs != NS_B)            begin n_fail++; $display("FAIL pacing_cs_count: got %0d want %0d", n_cs, NS_B); end
        n_checks++; if (n_wr != NS_B)            begin n_fail++; $display("FAIL pacing_write_count: got %0d want %0d", n_wr, NS_B); end
        n_checks++; if (done_cyc != FRAME_B - 1) begin n_fail++; $display("FAIL pacing_frame_length: got %0d want %0d", done_cyc, FRAME_B - 1); end
    endtask

    initial begin
        model_data[0] = 12'hABC;
        model_data[1] = 12'h123;
        model_data[2] = 12'hFFF;
        model_data[3] = 12'h000;
        model_data[4] = 12'h800;
        model_data[5] = 12'h001;
        model_data[6] = 12'h5A5;
        model_data[7] = 12'h7FF;
        test_reset();
        test_single_frame();
        test_start_held();
        test_abort();
        test_abort_start_idle();
        test_async_reset();
        test_single_frame();
        test_cs_pacing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
